// File: rtl/textbuf_pkg.sv
// Shared sizing defaults, character codes and controller states for the text buffer writer.
package textbuf_pkg;

  localparam int DEF_ROWS = 32;
  localparam int DEF_COLS = 32;
  localparam int DEF_CW   = 7;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_t;

endpackage

// File: rtl/textbuf_ram.sv
// Character cell storage: one synchronous write port and one registered read port.
module textbuf_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int CW    = 7,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);

  logic [CW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Separate read register so a same-address write in the same cycle returns old contents.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= RST_VAL;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/textbuf_writer.sv
// Terminal-style character writer: interprets a character stream into a ROWS x COLS text buffer.
module textbuf_writer
  import textbuf_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int CW   = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_char,
  input  logic [4:0]    rd_row,
  input  logic [4:0]    rd_col,
  output logic [CW-1:0] rd_digit,
  output logic [4:0]    cur_row,
  output logic [4:0]    cur_col,
  output logic          busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);

  localparam logic [CW-1:0] C_SPACE = CW'(CH_SPACE);
  localparam logic [CW-1:0] C_TILDE = CW'(CH_TILDE);
  localparam logic [CW-1:0] C_CR    = CW'(CH_CR);
  localparam logic [CW-1:0] C_LF    = CW'(CH_LF);
  localparam logic [CW-1:0] C_BS    = CW'(CH_BS);
  localparam logic [CW-1:0] C_FF    = CW'(CH_FF);

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt;
  logic [4:0]    row_next, col_next, row_inc;
  logic          printable, last_cell;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] r, input logic [4:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  assign printable = (in_char >= C_SPACE) && (in_char <= C_TILDE);
  assign row_inc   = (cur_row == 5'(ROWS - 1)) ? 5'd0 : cur_row + 5'd1;
  assign last_cell = (state == CLR_ALL) ? (clr_cnt == AW'(CELLS - 1))
                                        : (clr_cnt == AW'(COLS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLR_ALL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    row_next   = cur_row;
    col_next   = cur_col;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (printable) begin
            if (cur_col == 5'(COLS - 1)) begin
              col_next   = 5'd0;
              row_next   = row_inc;
              state_next = CLR_LINE;
            end else begin
              col_next = cur_col + 5'd1;
            end
          end else begin
            case (in_char)
              C_CR: col_next = 5'd0;
              C_LF: begin
                row_next   = row_inc;
                state_next = CLR_LINE;
              end
              C_BS: if (cur_col != 5'd0) col_next = cur_col - 5'd1;
              C_FF: begin
                row_next   = 5'd0;
                col_next   = 5'd0;
                state_next = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE, CLR_ALL: if (last_cell) state_next = IDLE;
      default:           state_next = CLR_ALL;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == CLR_LINE) || (state == CLR_ALL);
    wr_en    = 1'b0;
    wr_addr  = cell_addr(cur_row, cur_col);
    wr_data  = C_SPACE;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (printable) begin
            wr_en   = 1'b1;
            wr_data = in_char;
          end else if (in_char == C_BS && cur_col != 5'd0) begin
            wr_en   = 1'b1;
            wr_addr = cell_addr(cur_row, cur_col - 5'd1);
          end
        end
      end
      CLR_LINE: begin
        wr_en   = 1'b1;
        wr_addr = cell_addr(cur_row, 5'(clr_cnt));
      end
      CLR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
      end
      default: ;
    endcase
  end

  // Counter restarts whenever a clear begins or ends, so each clear sweeps from cell 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_row <= 5'd0;
      cur_col <= 5'd0;
      clr_cnt <= '0;
    end else begin
      cur_row <= row_next;
      cur_col <= col_next;
      if (state_next != state) clr_cnt <= '0;
      else if (state != IDLE)  clr_cnt <= clr_cnt + AW'(1);
    end
  end

  textbuf_ram #(
    .DEPTH  (CELLS),
    .AW     (AW),
    .CW     (CW),
    .RST_VAL(C_SPACE)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(cell_addr(rd_row, rd_col)),
    .rd_data(rd_digit)
  );

endmodule

// File: tb/tb_textbuf_writer.sv
// Scoreboard bench for textbuf_writer: a screen-array model predicts cursor moves and cell contents.
module tb_textbuf_writer;

  localparam int ROWS = 32;
  localparam int COLS = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_char = 7'h00;
  logic [4:0] rd_row = 5'd0;
  logic [4:0] rd_col = 5'd0;
  logic [6:0] rd_digit;
  logic [4:0] cur_row, cur_col;
  logic       busy;

  textbuf_writer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_char (in_char),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_digit(rd_digit),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] screen [ROWS][COLS];
  int         mr, mc;
  logic [9:0] exp_cur[$];
  logic [6:0] exp_rd[$];
  bit         rd_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) screen[r][c] = 7'h20;
    mr = 0;
    mc = 0;
  endtask

  // Terminal semantics; returns the number of clear cycles the character should trigger.
  task automatic model_apply(input logic [6:0] ch, output int clr);
    clr = 0;
    if (ch >= 7'h20 && ch <= 7'h7E) begin
      screen[mr][mc] = ch;
      if (mc == COLS - 1) begin
        mc  = 0;
        mr  = (mr + 1) % ROWS;
        clr = COLS;
      end else mc++;
    end else if (ch == 7'h0D) mc = 0;
    else if (ch == 7'h0A) begin
      mr  = (mr + 1) % ROWS;
      clr = COLS;
    end else if (ch == 7'h08) begin
      if (mc > 0) begin
        mc--;
        screen[mr][mc] = 7'h20;
      end
    end else if (ch == 7'h0C) begin
      mr  = 0;
      mc  = 0;
      clr = ROWS * COLS;
    end
    if (clr == COLS) for (int c = 0; c < COLS; c++) screen[mr][c] = 7'h20;
    if (clr == ROWS * COLS) model_reset();
  endtask

  // Monitor: compares cursor after every transfer and rd_digit after every issued read.
  initial begin
    bit pend_x = 1'b0;
    bit pend_r = 1'b0;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (pend_x) begin
        if (exp_cur.size() == 0) check("cursor_queue_empty", 0, 1);
        else begin
          e = exp_cur.pop_front();
          check("cursor_row", cur_row, e[9:5]);
          check("cursor_col", cur_col, e[4:0]);
        end
      end
      if (pend_r) begin
        if (exp_rd.size() == 0) check("read_queue_empty", 0, 1);
        else check("cell_read", rd_digit, exp_rd.pop_front());
      end
      pend_x = in_valid && in_ready && rst_n;
      pend_r = rd_chk;
    end
  end

  task automatic send(input logic [6:0] ch);
    int clr, n;
    bit ok, bad;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_char  = ch;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      return;
    end
    model_apply(ch, clr);
    exp_cur.push_back({5'(mr), 5'(mc)});
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (clr > 0) begin
      n = 0;
      bad = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (!busy) break;
        n++;
        if (in_ready) bad = 1'b1;
      end
      check("busy_cycles", n, clr);
      check("ready_low_while_busy", bad, 0);
    end else begin
      @(negedge clk);
      check("ready_after_char", in_ready, 1);
    end
  endtask

  task automatic read_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < COLS; c++) begin
        @(posedge clk); #1;
        rd_row = 5'(r);
        rd_col = 5'(c);
        rd_chk = 1'b1;
        exp_rd.push_back(screen[r][c]);
      end
    @(posedge clk); #1 rd_chk = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_rd_digit", rd_digit, 7'h20);
    check("rst_cur_row", cur_row, 0);
    check("rst_cur_col", cur_col, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic count_ready(input int req);
    int n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    check("ready_delay_after_reset", n, req);
  endtask

  function automatic logic [6:0] rand_char();
    int r = $urandom_range(99);
    if (r < 70) return 7'($urandom_range(8'h7E, 8'h20));
    if (r < 78) return 7'h0D;
    if (r < 86) return 7'h0A;
    if (r < 93) return 7'h08;
    if (r < 94) return 7'h0C;
    case ($urandom_range(3))
      0:       return 7'h00;
      1:       return 7'h1B;
      2:       return 7'h7F;
      default: return 7'h09;
    endcase
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset(3);
    count_ready(ROWS * COLS);
    read_rows(0, ROWS - 1);

    send(7'h48);
    send(7'h69);
    read_rows(0, 0);

    send(7'h0D);
    repeat (COLS) send(7'h41);
    read_rows(0, 1);

    send(7'h0C);
    repeat (ROWS - 1) send(7'h0A);
    repeat (5) send(7'h78);
    send(7'h0A);
    read_rows(0, 0);
    read_rows(ROWS - 1, ROWS - 1);

    send(7'h0D);
    send(7'h61);
    send(7'h62);
    send(7'h63);
    send(7'h08);
    read_rows(0, 0);
    send(7'h0D);
    send(7'h08);
    send(7'h0C);
    read_rows(0, 1);

    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      send(rand_char());
      if (i % 100 == 99) read_rows(mr, mr);
    end
    read_rows(0, ROWS - 1);

    do_reset(2);
    repeat (500) @(negedge clk);
    do_reset(2);
    count_ready(ROWS * COLS);
    read_rows(0, 1);
    send(7'h5A);
    read_rows(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
